// File: rtl/dds_word_loader_if.sv
// Host-side command and readback handshake for the DDS word loader.
// The master is the host; the slave is the loader.
interface dds_word_loader_if;
  logic       host_valid;
  logic       host_ready;
  logic [1:0] host_op;
  logic [7:0] host_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;

  modport master (
    output host_valid, host_op, host_data, rd_ready,
    input  host_ready, rd_valid, rd_data
  );

  modport slave (
    input  host_valid, host_op, host_data, rd_ready,
    output host_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/dds_word_loader.sv
// Host command stage for the DDS phase accumulator: assembles words bytewise,
// commits them over the shared mode/fph/word bus and streams readbacks MSB first.
module dds_word_loader #(
  parameter int unsigned M = 48
) (
  input  logic             clk,
  input  logic             reset,
  dds_word_loader_if.slave host,
  output logic [1:0]       mode,
  output logic             fph,
  inout  wire  [M-1:0]     word
);
  localparam int unsigned BYTES = M / 8;
  localparam int unsigned CntW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StStream} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    shadow_q, shadow_d;
  logic [M-1:0]    rdbuf_q, rdbuf_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fph_q, fph_d;

  // Loader owns the bus only during the single WRITE cycle.
  assign word = (state_q == StWrite) ? shadow_q : {M{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      rdbuf_q  <= '0;
      cnt_q    <= '0;
      fph_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rdbuf_q  <= rdbuf_d;
      cnt_q    <= cnt_d;
      fph_q    <= fph_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    shadow_d        = shadow_q;
    rdbuf_d         = rdbuf_q;
    cnt_d           = cnt_q;
    fph_d           = fph_q;
    mode            = 2'b00;
    fph             = 1'b0;
    host.host_ready = 1'b0;
    host.rd_valid   = 1'b0;
    host.rd_data    = rdbuf_q[M-1 -: 8];

    unique case (state_q)
      StIdle: begin
        host.host_ready = 1'b1;
        if (host.host_valid) begin
          unique case (host.host_op)
            2'b00: shadow_d = {shadow_q[M-9:0], host.host_data};
            2'b01: begin
              fph_d   = 1'b1;
              state_d = StWrite;
            end
            2'b10: begin
              fph_d   = 1'b0;
              state_d = StWrite;
            end
            2'b11: begin
              fph_d   = host.host_data[0];
              state_d = StRead;
            end
            default: ;
          endcase
        end
      end
      StWrite: begin
        mode    = 2'b11;
        fph     = fph_q;
        state_d = StIdle;
      end
      StRead: begin
        mode    = 2'b10;
        fph     = fph_q;
        rdbuf_d = word;
        cnt_d   = CntW'(BYTES - 1);
        state_d = StStream;
      end
      StStream: begin
        host.rd_valid = 1'b1;
        if (host.rd_ready) begin
          rdbuf_d = {rdbuf_q[M-9:0], 8'h00};
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: doc/dds_word_loader.md
# dds_word_loader

Host-side control stage sitting directly upstream of the DDS phase accumulator. It accepts byte-wide commands from a host, assembles M-bit frequency-tuning or phase words in a shadow register, and sequences the accumulator's shared `mode`/`fph`/`word` bus to commit them. It also reads back the live frequency or phase word and streams it to the host one byte at a time, MSB first. Outside a command the accumulator is left in run mode (`mode=00`).

## Interface
- `M`, 48: accumulator word width; must be a multiple of 8. Derived: `BYTES = M/8`.

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted)
- `host_valid`  in  1  host command present
- `host_ready`  out  1  loader can accept a command this cycle
- `host_op`  in  2  00 shift byte, 01 commit freq, 10 commit phase, 11 read
- `host_data`  in  8  payload: byte for op 00; bit0 selects the read target for op 11 (1 = freq, 0 = phase)
- `rd_valid`  out  1  readback byte available
- `rd_ready`  in  1  host consumes the readback byte
- `rd_data`  out  8  readback byte
- `mode`  out  2  to accumulator: 00 run, 10 read, 11 write
- `fph`  out  1  to accumulator: 1 = frequency register, 0 = phase accumulator
- `word`  inout  M  shared bus; driven only while `mode=11`, else high-Z

## Operation
- **States:** IDLE, WRITE, READ, STREAM. State is registered; `mode`, `fph`, `host_ready`, `rd_valid` and the `word` enable decode from registered state only.
- **IDLE:**
  - `mode=00`, `host_ready=1`, `rd_valid=0`.
  - A command is accepted when `host_valid && host_ready`.
  - op 00: `shadow <= {shadow[M-9:0], host_data}`. Stay in IDLE. Back-to-back shifts are allowed every cycle.
  - op 01 / 10: latch `fph_r` = 1 / 0, go to WRITE. The shadow is not cleared.
  - op 11: latch `fph_r = host_data[0]`, go to READ.
- **WRITE** (exactly 1 cycle):
  - `mode=11`, `fph=fph_r`, `word=shadow`, `host_ready=0`.
  - The accumulator loads on the closing edge. Go to IDLE.
- **READ** (exactly 1 cycle):
  - `mode=10`, `fph=fph_r`, `word` high-Z (the accumulator drives it).
  - On the closing edge: `rdbuf <= word`, `cnt <= BYTES-1`. Go to STREAM.
- **STREAM:**
  - `mode=00`, `host_ready=0`, `rd_valid=1`, `rd_data=rdbuf[M-1:M-8]`.
  - On `rd_ready`: `rdbuf <= rdbuf << 8`, `cnt <= cnt-1`.
  - When `rd_ready` arrives with `cnt==0`, go to IDLE.
  - With `rd_ready` held low, `rd_data` and `rd_valid` stay stable indefinitely.
- **Bus safety:** the loader never drives `word` while `mode != 11`. The accumulator drives only in `mode=10`, so there is no contention.
- **Reset:**
  - Asserting `reset` (low) forces, asynchronously: IDLE, `shadow=0`, `rdbuf=0`, `cnt=0`, `fph_r=0`.
  - Outputs during and after reset: `mode=00`, `fph=0`, `word` high-Z, `rd_valid=0`, `rd_data=0`, `host_ready=1`.
  - Host handshakes seen while `reset` is low are ignored.
  - A reset mid-WRITE aborts the load and releases the bus immediately. A reset mid-STREAM discards the remaining bytes.

## Timing
- Shift: the byte is visible in `shadow` 1 cycle after acceptance.
- Commit: accept at edge k; `mode=11` during cycle k..k+1; accumulator register updated at edge k+1; `host_ready` returns high in cycle k+1.
- Run-mode cost of a commit: the accumulator skips exactly one increment.
- Read: accept at edge k; `mode=10` during cycle k..k+1; `rdbuf` captured at edge k+1; first `rd_valid` in cycle k+1.
  - The captured phase is the accumulator value held during the READ cycle. It is not incremented in that cycle.
- Streaming: with `rd_ready` held high, a read completes in `BYTES` cycles of STREAM. `host_ready=1` on the cycle after the last byte.
- `host_valid` that arrives in a non-IDLE state waits. The host must hold the command stable until `host_ready`.

## Test plan
- **Freq load:** after reset, shift 00,00,00,01,00,00 then commit freq. Expect `mode=11`, `fph=1`, `word=48'h0000_0001_0000` for exactly 1 cycle. The accumulator then advances by `48'h10000` per cycle.
- **Read freq:** after the load above, issue read with `host_data=8'h01`, `rd_ready=1`. Expect `mode=10` for 1 cycle, then `rd_data` = 00,00,00,01,00,00 on 6 consecutive cycles, then `host_ready=1`.
- **Phase read under backpressure:** freq=1, phase=0, run 100 cycles, read phase with `rd_ready` toggling 1/0. Expect bytes stable while `rd_ready=0`, and a reassembled value equal to the run-cycle count at capture (exactly 100 if no prior commit/read pauses).
- **Phase write:** shift `12 34 56 78 9A BC`, commit phase with freq=0. Expect the accumulator to hold `48'h123456789ABC`; a readback returns the same value.
- **Bus contention check:** monitor every cycle and assert that `word` is never driven by both sides and never X while `mode` is 10 or 11.
- **Reset mid-operation:** assert `reset` low during WRITE and again during byte 3 of STREAM. Expect immediately `mode=00`, `word` Z, `rd_valid=0`. After release `host_ready=1`, `shadow=0`, and an immediate read returns 0.
